// File: rtl/avalon_mm_reg_slave_if.sv
// Avalon-MM command/response bundle between a test master and the register-bank slave.
// The master drives the command fields; the slave answers with waitrequest and readdata.
interface avalon_mm_reg_slave_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8
);
   logic [ADDR_W-1:0] address;
   logic              write;
   logic              read;
   logic [DATA_W-1:0] writedata;
   logic              waitrequest;
   logic [DATA_W-1:0] readdata;

   modport master (
      output address, write, read, writedata,
      input  waitrequest, readdata
   );

   modport slave (
      input  address, write, read, writedata,
      output waitrequest, readdata
   );
endinterface

// File: rtl/avalon_mm_reg_slave.sv
// Avalon-MM register-bank slave: each new command is stretched by a WAIT_CYCLES waitrequest pulse
// and executed on the falling edge of waitrequest; address 0 holds {err_count, txn_count}.
module avalon_mm_reg_slave #(
   parameter int NUM_REGS    = 8,
   parameter int WAIT_CYCLES = 2,
   parameter int ADDR_W      = 8,
   parameter int DATA_W      = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   avalon_mm_reg_slave_if.slave bus
);

   typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_BUSY} state_t;

   state_t              r_state;
   state_t              w_state_next;
   logic [3:0]          r_wait_cnt;
   logic [3:0]          w_wait_cnt_next;
   logic                r_waitrequest;
   logic                w_waitrequest_next;
   logic                r_prev_none;
   logic                r_cmd_read;
   logic                r_cmd_write;
   logic [ADDR_W-1:0]   r_cmd_addr;
   logic [DATA_W-1:0]   r_cmd_data;
   logic [3:0]          r_txn_count;
   logic [3:0]          r_err_count;
   logic [DATA_W-1:0]   r_readdata;
   logic [DATA_W-1:0]   r_regs [NUM_REGS];

   logic                w_cmd_active;
   logic                w_cmd_new;
   logic                w_accept;
   logic                w_complete;
   logic                w_both;
   logic                w_out_of_range;
   logic                w_is_status;
   logic                w_err;
   logic                w_do_reg_write;
   logic [3:0]          w_err_inc;
   logic [DATA_W-1:0]   w_reg_rdata;
   logic [NUM_REGS-1:0] w_reg_we;

   // A command held steady across cycles is the same transfer, so it must not be accepted twice.
   assign w_cmd_active   = bus.read | bus.write;
   assign w_cmd_new      = r_prev_none ||
                           ({bus.read, bus.write, bus.address, bus.writedata} !=
                            {r_cmd_read, r_cmd_write, r_cmd_addr, r_cmd_data});
   assign w_accept       = (r_state == ST_IDLE) && w_cmd_active && w_cmd_new;
   assign w_complete     = (r_state == ST_BUSY) && (r_wait_cnt == 4'd1);

   assign w_both         = r_cmd_read & r_cmd_write;
   assign w_out_of_range = r_cmd_addr > ADDR_W'(NUM_REGS);
   assign w_is_status    = (r_cmd_addr == '0);
   assign w_err          = w_both | w_out_of_range;
   assign w_do_reg_write = w_complete && r_cmd_write && !w_err && !w_is_status;
   assign w_err_inc      = (r_err_count == 4'hF) ? 4'hF : r_err_count + 4'd1;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg_we
         assign w_reg_we[gi] = w_do_reg_write && (r_cmd_addr == ADDR_W'(gi + 1));
      end
   endgenerate

   always_comb begin
      w_reg_rdata = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (r_cmd_addr == ADDR_W'(i + 1)) begin
            w_reg_rdata = r_regs[i];
         end
      end
   end

   always_comb begin
      w_state_next       = r_state;
      w_wait_cnt_next    = r_wait_cnt;
      w_waitrequest_next = r_waitrequest;
      case (r_state)
         ST_INIT: begin
            w_state_next       = ST_IDLE;
            w_waitrequest_next = 1'b0;
         end
         ST_IDLE: begin
            if (w_accept) begin
               w_state_next       = ST_BUSY;
               w_wait_cnt_next    = 4'(WAIT_CYCLES);
               w_waitrequest_next = 1'b1;
            end
         end
         ST_BUSY: begin
            w_wait_cnt_next = r_wait_cnt - 4'd1;
            if (w_complete) begin
               w_state_next       = ST_IDLE;
               w_waitrequest_next = 1'b0;
            end
         end
         default: begin
            w_state_next       = ST_INIT;
            w_waitrequest_next = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state       <= ST_INIT;
         r_wait_cnt    <= 4'd0;
         r_waitrequest <= 1'b1;
      end else begin
         r_state       <= w_state_next;
         r_wait_cnt    <= w_wait_cnt_next;
         r_waitrequest <= w_waitrequest_next;
      end
   end

   // Error commands still complete normally; only the counters record them.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_prev_none <= 1'b1;
         r_cmd_read  <= 1'b0;
         r_cmd_write <= 1'b0;
         r_cmd_addr  <= '0;
         r_cmd_data  <= '0;
         r_txn_count <= 4'd0;
         r_err_count <= 4'd0;
         r_readdata  <= '0;
         for (int i = 0; i < NUM_REGS; i++) begin
            r_regs[i] <= '0;
         end
      end else begin
         r_prev_none <= ~w_cmd_active;
         if (w_accept) begin
            r_cmd_read  <= bus.read;
            r_cmd_write <= bus.write;
            r_cmd_addr  <= bus.address;
            r_cmd_data  <= bus.writedata;
         end
         for (int i = 0; i < NUM_REGS; i++) begin
            if (w_reg_we[i]) begin
               r_regs[i] <= r_cmd_data;
            end
         end
         if (w_complete) begin
            if (w_err) begin
               r_err_count <= w_err_inc;
               if (!w_both && r_cmd_read) begin
                  r_readdata <= '1;
               end
            end else if (w_is_status) begin
               if (r_cmd_write) begin
                  r_txn_count <= 4'd0;
                  r_err_count <= 4'd0;
               end else begin
                  r_readdata  <= DATA_W'({r_err_count, r_txn_count});
                  r_txn_count <= r_txn_count + 4'd1;
               end
            end else begin
               if (r_cmd_read) begin
                  r_readdata <= w_reg_rdata;
               end
               r_txn_count <= r_txn_count + 4'd1;
            end
         end
      end
   end

   assign bus.waitrequest = r_waitrequest;
   assign bus.readdata    = r_readdata;

endmodule

// File: tb/tb_avalon_mm_reg_slave.sv
// Bench for avalon_mm_reg_slave: directed scenarios with literal expectations, then random traffic,
// all cross-checked every cycle against a transaction-level model of the register bank.
module tb_avalon_mm_reg_slave;
   localparam int NUM_REGS    = 8;
   localparam int WAIT_CYCLES = 2;
   localparam int ADDR_W      = 8;
   localparam int DATA_W      = 8;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   avalon_mm_reg_slave_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   avalon_mm_reg_slave #(
      .NUM_REGS   (NUM_REGS),
      .WAIT_CYCLES(WAIT_CYCLES),
      .ADDR_W     (ADDR_W),
      .DATA_W     (DATA_W)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Transaction-level view: pending command, cycles of stall left, register and counter contents.
   typedef struct packed {
      logic                     init;
      logic [4:0]               busy_left;
      logic                     prev_none;
      logic                     c_rd;
      logic                     c_wr;
      logic [7:0]               c_addr;
      logic [7:0]               c_data;
      logic [3:0]               txn;
      logic [3:0]               err;
      logic [7:0]               rdata;
      logic [NUM_REGS-1:0][7:0] regs;
   } model_t;

   function automatic model_t model_reset();
      model_t r;
      r           = '0;
      r.init      = 1'b1;
      r.prev_none = 1'b1;
      return r;
   endfunction

   function automatic logic [3:0] sat_inc(input logic [3:0] v);
      int e;
      e = int'(v) + 1;
      if (e > 15) e = 15;
      return 4'(e);
   endfunction

   function automatic model_t model_step(input model_t s, input logic rd, input logic wr,
                                         input logic [7:0] a, input logic [7:0] d);
      model_t n;
      n           = s;
      n.prev_none = !(rd | wr);
      if (s.init) begin
         n.init = 1'b0;
      end else if (s.busy_left != 0) begin
         n.busy_left = s.busy_left - 5'd1;
         if (n.busy_left == 0) begin
            if (s.c_rd && s.c_wr) begin
               n.err = sat_inc(s.err);
            end else if (int'(s.c_addr) > NUM_REGS) begin
               n.err = sat_inc(s.err);
               if (s.c_rd) n.rdata = 8'hFF;
            end else if (s.c_addr == 8'd0) begin
               if (s.c_wr) begin
                  n.txn = 4'd0;
                  n.err = 4'd0;
               end else begin
                  n.rdata = {s.err, s.txn};
                  n.txn   = s.txn + 4'd1;
               end
            end else begin
               for (int i = 0; i < NUM_REGS; i++) begin
                  if (int'(s.c_addr) == i + 1) begin
                     if (s.c_wr) n.regs[i] = s.c_data;
                     else        n.rdata   = s.regs[i];
                  end
               end
               n.txn = s.txn + 4'd1;
            end
         end
      end else if ((rd | wr) &&
                   (s.prev_none || ({rd, wr, a, d} != {s.c_rd, s.c_wr, s.c_addr, s.c_data}))) begin
         n.busy_left = 5'(WAIT_CYCLES);
         n.c_rd      = rd;
         n.c_wr      = wr;
         n.c_addr    = a;
         n.c_data    = d;
      end
      return n;
   endfunction

   model_t m;
   always @(posedge clk or posedge reset) begin
      if (reset) m <= model_reset();
      else       m <= model_step(m, bus.read, bus.write, bus.address, bus.writedata);
   end

   always @(negedge clk) begin
      check("model_waitrequest", {31'b0, bus.waitrequest}, {31'b0, (m.init || m.busy_left != 0)});
      check("model_readdata", {24'b0, bus.readdata}, {24'b0, m.rdata});
   end

   task automatic drive_idle();
      bus.read      = 1'b0;
      bus.write     = 1'b0;
      bus.address   = '0;
      bus.writedata = '0;
   endtask

   task automatic do_cmd(input logic rd_i, input logic wr_i, input logic [7:0] a,
                         input logic [7:0] d, input bit keep, output logic [7:0] rdata);
      int t;
      int hi;
      @(negedge clk);
      bus.read      = rd_i;
      bus.write     = wr_i;
      bus.address   = a;
      bus.writedata = d;
      t = 0;
      do begin
         @(negedge clk);
         t++;
      end while (!bus.waitrequest && t < 20);
      check("wait_rise", {31'b0, bus.waitrequest}, 32'd1);
      hi = 0;
      while (bus.waitrequest && hi < 40) begin
         hi++;
         @(negedge clk);
      end
      check("wait_len", hi, WAIT_CYCLES);
      rdata = bus.readdata;
      $display("txn rd=%0b wr=%0b addr=%0d wdata=0x%02h -> readdata=0x%02h stall=%0d",
               rd_i, wr_i, a, d, rdata, hi);
      if (!keep) drive_idle();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, required completion");
      $fatal(1, "watchdog");
   end

   logic [7:0] rd;
   int         sel;

   initial begin
      drive_idle();
      reset = 1'b1;
      repeat (20) begin
         @(negedge clk);
         check("rst_waitrequest", {31'b0, bus.waitrequest}, 32'd1);
         check("rst_readdata", {24'b0, bus.readdata}, 32'd0);
      end
      #2 reset = 1'b0;
      #1 check("init_waitrequest", {31'b0, bus.waitrequest}, 32'd1);
      @(negedge clk);
      check("idle_waitrequest", {31'b0, bus.waitrequest}, 32'd0);

      // Held write accepted once, then status and data reads.
      do_cmd(1'b0, 1'b1, 8'd1, 8'd181, 1'b1, rd);
      repeat (5) begin
         @(negedge clk);
         check("held_no_reaccept", {31'b0, bus.waitrequest}, 32'd0);
      end
      do_cmd(1'b1, 1'b0, 8'd0, 8'd0, 1'b0, rd);
      check("status_after_held_write", {24'b0, rd}, 32'h01);
      do_cmd(1'b1, 1'b0, 8'd1, 8'd0, 1'b0, rd);
      check("read_reg1", {24'b0, rd}, 32'd181);
      check("model_reg1", {24'b0, m.regs[0]}, 32'd181);

      // Simultaneous read and write is an error with a full pulse.
      do_cmd(1'b1, 1'b1, 8'd3, 8'd200, 1'b0, rd);
      check("both_rdata_held", {24'b0, rd}, 32'd181);
      do_cmd(1'b1, 1'b0, 8'd3, 8'd0, 1'b0, rd);
      check("reg3_untouched", {24'b0, rd}, 32'd0);
      do_cmd(1'b1, 1'b0, 8'd0, 8'd0, 1'b0, rd);
      check("status_err1", {24'b0, rd}, 32'h14);

      // Out-of-range reads and error saturation.
      do_cmd(1'b1, 1'b0, 8'd9, 8'd0, 1'b0, rd);
      check("oor_read", {24'b0, rd}, 32'hFF);
      for (int i = 0; i < 15; i++) begin
         do_cmd(1'b1, 1'b0, 8'($urandom_range(9, 255)), 8'd0, 1'b0, rd);
      end
      do_cmd(1'b1, 1'b0, 8'd0, 8'd0, 1'b0, rd);
      check("err_saturated", {24'b0, rd}, 32'hF5);
      check("model_err_sat", {28'b0, m.err}, 32'd15);

      // Clear, 17 valid transactions wrap txn, clear again.
      do_cmd(1'b0, 1'b1, 8'd0, 8'd0, 1'b0, rd);
      for (int i = 0; i < 17; i++) begin
         do_cmd(1'b0, 1'b1, 8'($urandom_range(1, NUM_REGS)), 8'($urandom), 1'b0, rd);
      end
      do_cmd(1'b1, 1'b0, 8'd0, 8'd0, 1'b0, rd);
      check("txn_wrap", {24'b0, rd}, 32'h01);
      do_cmd(1'b0, 1'b1, 8'd0, 8'd0, 1'b0, rd);
      do_cmd(1'b1, 1'b0, 8'd0, 8'd0, 1'b0, rd);
      check("status_cleared", {24'b0, rd}, 32'h00);

      // Reset while a write is stalled discards it.
      @(negedge clk);
      bus.write     = 1'b1;
      bus.address   = 8'd2;
      bus.writedata = 8'd210;
      @(negedge clk);
      check("busy_before_reset", {31'b0, bus.waitrequest}, 32'd1);
      #2 reset = 1'b1;
      drive_idle();
      repeat (3) begin
         @(negedge clk);
         check("reset_mid_busy_wait", {31'b0, bus.waitrequest}, 32'd1);
      end
      check("reset_mid_busy_rdata", {24'b0, bus.readdata}, 32'd0);
      #2 reset = 1'b0;
      #1 check("reinit_waitrequest", {31'b0, bus.waitrequest}, 32'd1);
      @(negedge clk);
      check("reidle_waitrequest", {31'b0, bus.waitrequest}, 32'd0);
      do_cmd(1'b1, 1'b0, 8'd2, 8'd0, 1'b0, rd);
      check("reg2_lost", {24'b0, rd}, 32'd0);

      // Random traffic: held, idle and fresh commands, including errors and clears.
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         sel = $urandom_range(0, 9);
         if (sel < 4) begin
            // keep current inputs
         end else if (sel < 6) begin
            drive_idle();
         end else begin
            bus.read      = 1'($urandom_range(0, 1));
            bus.write     = bus.read ? ($urandom_range(0, 4) == 0) : 1'b1;
            bus.address   = 8'($urandom_range(0, 11));
            bus.writedata = 8'($urandom);
         end
      end
      drive_idle();
      repeat (10) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/avalon_mm_reg_slave.md
Name: avalon_mm_reg_slave

Overview:
- Avalon-MM slave register bank: the responder end for the team's Avalon-MM master test modules.
- Accepts single read/write commands and stretches each one with a programmable waitrequest pulse.
- Completion is signalled by the falling edge of waitrequest.
- Holds NUM_REGS data registers plus a status register of transaction and error counters.

Parameters:
NUM_REGS, 8, number of data registers, mapped at addresses 1..NUM_REGS (legal 1..254)
WAIT_CYCLES, 2, cycles waitrequest stays high per accepted command (legal 1..15)
ADDR_W, 8, address width
DATA_W, 8, data width (min 8)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
address  in  ADDR_W  register address
write  in  1  write strobe
read  in  1  read strobe
writedata  in  DATA_W  write data
waitrequest  out  1  high = busy/stall; falling edge = command complete
readdata  out  DATA_W  read data, registered, held until next read completes

Behaviour:
- One clock; reset is asynchronous and active-high.
- Reset (async assert) values:
  - waitrequest=1, readdata=0.
  - All data registers 0; txn_count=0; err_count=0; state=INIT.
  - Any pending command is discarded.
- FSM states: INIT, IDLE, BUSY.
- INIT:
  - waitrequest=1.
  - First rising edge after reset release -> IDLE with waitrequest=0.
- IDLE, waitrequest=0: a command is accepted on a rising edge when (read|write)=1 and the command is new.
  - New = the previous cycle had read=write=0, or {read,write,address,writedata} differs from the last accepted command.
  - A command held unchanged is not re-accepted.
  - On acceptance: latch command, load wait counter with WAIT_CYCLES, register waitrequest=1, go to BUSY.
- BUSY:
  - Counter decrements each edge; inputs are ignored.
  - On the edge where it reaches 0: execute the latched command, register waitrequest=0, go to IDLE.
  - waitrequest is therefore high for exactly WAIT_CYCLES clock periods.
  - The completion edge is not itself an acceptance edge; the earliest next acceptance is one edge later.
- Execution at the completion edge:
  - write to addr 1..NUM_REGS: reg[addr-1] <= writedata; txn_count++.
  - read of addr 1..NUM_REGS: readdata <= reg[addr-1]; txn_count++.
  - read of addr 0: readdata <= {err_count[3:0], txn_count[3:0]}, upper bits 0, using pre-increment values; then txn_count++.
  - write to addr 0: txn_count <= 0, err_count <= 0. Clear takes precedence; there is no increment on this command.
  - addr > NUM_REGS: no register change; a read returns readdata <= all-ones (0xFF at DATA_W=8); err_count++.
  - read=1 and write=1: no register change; readdata unchanged; err_count++.
  - Error commands still get the full waitrequest pulse, so the master never hangs.
- Counter widths:
  - txn_count: 4-bit, wraps 15 -> 0.
  - err_count: 4-bit, saturates at 15.
- Data register writes only occur at a BUSY completion edge; no write-through from IDLE.
- Reset mid-BUSY:
  - The latched write is lost and waitrequest returns to 1.
  - The block goes through INIT again.

Test Plan:
- Reset 20 cycles, release -> waitrequest 1 until first edge after release, then 0; readdata=0.
- write addr1 data181 held; then read addr1 -> waitrequest high exactly 2 cycles per command, readdata=181 at the read's falling edge; the held write is accepted only once (txn_count=1 before the read).
- write addr3=200 with read=1,write=1 -> pulse occurs, reg3 stays 0; a later read of addr0 returns err=1 in upper nibble.
- read addr9 (NUM_REGS=8) -> readdata=0xFF, err_count+1; 16 errors -> err_count stays 15.
- 17 valid transactions then read addr0 -> txn nibble = 1 (wrap); write addr0 -> read addr0 returns 0x00.
- Assert reset during BUSY of write addr2=210 -> reg2=0 afterwards, waitrequest 1 during reset, INIT->IDLE after release.
